pcie_rd_chk_ml: RTL and testbench

Multi-lane running-disparity (RD) checker for 10-bit 8b/10b symbols on the PCIe receive path. Each lane keeps its own RD state machine, flags disparity violations and counts them in saturating counters. Sits after symbol alignment and before the 10b/8b decoder. Generalises the single-lane CRD checker to LANES lanes, with valid qualification, per-lane enable, invalid-weight detection and error statistics.

---
 rtl/pcie_rd_chk_ml.sv | 130 +++++++++++++
 tb/tb_pcie_rd_chk_ml.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pcie_rd_chk_ml.sv
// pcie_rd_chk_ml: multi-lane 8b/10b running-disparity checker with
// per-lane violation pulses, saturating error counters and a sticky flag.
// Optional feature macro: CRD_WEIGHT_CHK_EN (invalid-weight detection).
module pcie_rd_chk_ml #(
  parameter int unsigned LANES = 4,
  parameter int unsigned SYM_W = 10,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sym_valid_i,
  input  logic [LANES*SYM_W-1:0]   sym_in_i,
  input  logic [LANES-1:0]         lane_en_i,
  input  logic                     clr_cnt_i,
  output logic [2*LANES-1:0]       rd_state_o,
  output logic [LANES-1:0]         rd_err_o,
  output logic [LANES*CNT_W-1:0]   err_cnt_o,
  output logic                     err_sticky_o
);

  localparam int unsigned WW = $clog2(SYM_W + 1);
  localparam int unsigned H  = SYM_W / 2;

  typedef enum logic [1:0] {
    RD_UNK = 2'b00,
    RD_POS = 2'b01,
    RD_NEG = 2'b10
  } rd_e;

  typedef enum logic [1:0] {
    CL_NEU = 2'b00,
    CL_POS = 2'b01,
    CL_NEG = 2'b10,
    CL_INV = 2'b11
  } cls_e;

  rd_e              state_q [LANES];
  logic [CNT_W-1:0] cnt_q   [LANES];
  logic [LANES-1:0] rd_err_q;
  logic             sticky_q;

  cls_e             cls_c      [LANES];
  logic [LANES-1:0] lane_err_c;

  function automatic logic [WW-1:0] popcnt(input logic [SYM_W-1:0] s);
    logic [WW-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(SYM_W); i++) acc = acc + WW'(s[i]);
    return acc;
  endfunction

  // Classify each lane symbol by weight and detect a disparity violation.
  always_comb begin
    for (int k = 0; k < int'(LANES); k++) begin
      logic [WW-1:0] w;
      w = popcnt(sym_in_i[k*SYM_W +: SYM_W]);
`ifdef CRD_WEIGHT_CHK_EN
      if (w == WW'(H))          cls_c[k] = CL_NEU;
      else if (w == WW'(H + 1)) cls_c[k] = CL_POS;
      else if (w == WW'(H - 1)) cls_c[k] = CL_NEG;
      else                      cls_c[k] = CL_INV;
`else
      if (w == WW'(H))          cls_c[k] = CL_NEU;
      else if (w > WW'(H))      cls_c[k] = CL_POS;
      else                      cls_c[k] = CL_NEG;
`endif
      lane_err_c[k] = sym_valid_i && lane_en_i[k] &&
                      ((cls_c[k] == CL_INV) ||
                       (cls_c[k] == CL_POS && state_q[k] == RD_POS) ||
                       (cls_c[k] == CL_NEG && state_q[k] == RD_NEG));
    end
  end

  // Per-lane RD state machines, error pulses, counters and sticky flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < int'(LANES); k++) begin
        state_q[k] <= RD_UNK;
        cnt_q[k]   <= '0;
      end
      rd_err_q <= '0;
      sticky_q <= 1'b0;
    end else begin
      for (int k = 0; k < int'(LANES); k++) begin
        rd_err_q[k] <= lane_err_c[k];

        if (!lane_en_i[k]) begin
          state_q[k] <= RD_UNK;
        end else if (sym_valid_i) begin
          if (cls_c[k] == CL_INV) begin
            state_q[k] <= RD_UNK;
          end else begin
            case (state_q[k])
              RD_UNK: begin
                if (cls_c[k] == CL_POS)      state_q[k] <= RD_POS;
                else if (cls_c[k] == CL_NEG) state_q[k] <= RD_NEG;
              end
              RD_POS: if (cls_c[k] == CL_NEG) state_q[k] <= RD_NEG;
              RD_NEG: if (cls_c[k] == CL_POS) state_q[k] <= RD_POS;
              default: state_q[k] <= RD_UNK;
            endcase
          end
        end

        // An error in the clearing cycle still counts as the first event.
        if (lane_err_c[k]) begin
          if (clr_cnt_i)               cnt_q[k] <= CNT_W'(1);
          else if (cnt_q[k] != '1)     cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end else if (clr_cnt_i) begin
          cnt_q[k] <= '0;
        end
      end
      sticky_q <= (sticky_q && !clr_cnt_i) || (|lane_err_c);
    end
  end

  // Pack per-lane registers onto the flat output buses.
  always_comb begin
    rd_state_o = '0;
    err_cnt_o  = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      rd_state_o[2*k +: 2]     = state_q[k];
      err_cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end

  assign rd_err_o     = rd_err_q;
  assign err_sticky_o = sticky_q;

endmodule

// File: tb/tb_pcie_rd_chk_ml.sv
// Directed self-checking bench for pcie_rd_chk_ml (4 lanes, 10-bit symbols,
// 2-bit counters so saturation is reachable).
module tb_pcie_rd_chk_ml;

  localparam int unsigned LANES = 4;
  localparam int unsigned SYM_W = 10;
  localparam int unsigned CNT_W = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   sym_valid;
  logic [LANES*SYM_W-1:0] sym_in;
  logic [LANES-1:0]       lane_en;
  logic                   clr_cnt;
  logic [2*LANES-1:0]     rd_state;
  logic [LANES-1:0]       rd_err;
  logic [LANES*CNT_W-1:0] err_cnt;
  logic                   err_sticky;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [9:0] NEU = 10'h155; // w=5
  localparam logic [9:0] P6  = 10'h3F0; // w=6
  localparam logic [9:0] P6B = 10'h30F; // w=6
  localparam logic [9:0] N4  = 10'h0F0; // w=4
  localparam logic [9:0] W10 = 10'h3FF; // w=10

  pcie_rd_chk_ml #(.LANES(LANES), .SYM_W(SYM_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .sym_valid_i (sym_valid),
    .sym_in_i    (sym_in),
    .lane_en_i   (lane_en),
    .clr_cnt_i   (clr_cnt),
    .rd_state_o  (rd_state),
    .rd_err_o    (rd_err),
    .err_cnt_o   (err_cnt),
    .err_sticky_o(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Present one cycle of inputs, clock it in, sample 1ns after the edge.
  task automatic step(input logic [9:0] s0, input logic [9:0] s1,
                      input logic [9:0] s2, input logic [9:0] s3,
                      input logic v, input logic [3:0] en, input logic clr);
    sym_in    = {s3, s2, s1, s0};
    sym_valid = v;
    lane_en   = en;
    clr_cnt   = clr;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] l2_after_w10;
  logic [3:0] multi_err;
  logic [7:0] multi_cnt;
  logic [1:0] sat_exp [5];

  initial begin
`ifdef CRD_WEIGHT_CHK_EN
    l2_after_w10 = 2'b00;
    multi_err    = 4'b1011;
    multi_cnt    = 8'h45;
`else
    l2_after_w10 = 2'b01;
    multi_err    = 4'b1111;
    multi_cnt    = 8'h55;
`endif
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    // Reset
    rst = 1'b0;
    step(P6, P6, P6, P6, 1'b1, 4'hF, 1'b0);
    step(P6, P6, P6, P6, 1'b1, 4'hF, 1'b0);
    chk("reset_state",  32'(rd_state),   32'h0);
    chk("reset_err",    32'(rd_err),     32'h0);
    chk("reset_cnt",    32'(err_cnt),    32'h0);
    chk("reset_sticky", 32'(err_sticky), 32'h0);
    rst = 1'b1;

    // Lane0 enters POS, lane1 enters NEG
    step(P6, N4, NEU, NEU, 1'b1, 4'hF, 1'b0);
    chk("s1_state", 32'(rd_state), 32'h09);
    chk("s1_err",   32'(rd_err),   32'h0);

    // Lane0 POS violation; lane1 neutral holds NEG
    step(P6B, NEU, NEU, NEU, 1'b1, 4'hF, 1'b0);
    chk("s2_err",    32'(rd_err),     32'h1);
    chk("s2_state",  32'(rd_state),   32'h09);
    chk("s2_cnt",    32'(err_cnt),    32'h01);
    chk("s2_sticky", 32'(err_sticky), 32'h1);

    // Lane1 NEG -> POS, no error; pulse drops
    step(NEU, P6, NEU, NEU, 1'b1, 4'hF, 1'b0);
    chk("s3_state",  32'(rd_state),   32'h05);
    chk("s3_err",    32'(rd_err),     32'h0);
    chk("s3_sticky", 32'(err_sticky), 32'h1);

    // Lane2 to POS, then an invalid-weight symbol
    step(NEU, NEU, P6, NEU, 1'b1, 4'hF, 1'b0);
    chk("l2_pos", 32'(rd_state[5:4]), 32'h1);
    step(NEU, NEU, W10, NEU, 1'b1, 4'hF, 1'b0);
    chk("l2_w10_err",   32'(rd_err),        32'h4);
    chk("l2_w10_state", 32'(rd_state[5:4]), 32'(l2_after_w10));
    chk("l2_w10_cnt",   32'(err_cnt),       32'h11);

    // Lane3 saturation with 2-bit counter
    step(NEU, NEU, NEU, P6, 1'b1, 4'hF, 1'b0);
    chk("l3_pos", 32'(rd_state[7:6]), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step(NEU, NEU, NEU, P6, 1'b1, 4'hF, 1'b0);
      chk("l3_sat_err", 32'(rd_err[3]),     32'h1);
      chk("l3_sat_cnt", 32'(err_cnt[7:6]),  32'(sat_exp[i]));
    end

    // Lane0 counter to 3, then clear in the same cycle as an error
    step(P6, NEU, NEU, NEU, 1'b1, 4'hF, 1'b0);
    step(P6, NEU, NEU, NEU, 1'b1, 4'hF, 1'b0);
    chk("l0_cnt3", 32'(err_cnt[1:0]), 32'h3);
    step(P6, NEU, NEU, NEU, 1'b1, 4'hF, 1'b1);
    chk("clr_err_cnt",    32'(err_cnt),    32'h01);
    chk("clr_err_sticky", 32'(err_sticky), 32'h1);
    step(NEU, NEU, NEU, NEU, 1'b1, 4'hF, 1'b1);
    chk("clr_cnt",    32'(err_cnt),    32'h0);
    chk("clr_sticky", 32'(err_sticky), 32'h0);

    // sym_valid=0 holds state and suppresses errors
    step(P6, P6, P6, P6, 1'b0, 4'hF, 1'b0);
    chk("novalid_err",   32'(rd_err),       32'h0);
    chk("novalid_state", 32'(rd_state[1:0]), 32'h1);

    // Simultaneous errors on several lanes
    step(P6, P6, P6, P6, 1'b1, 4'hF, 1'b0);
    chk("multi_err", 32'(rd_err),  32'(multi_err));
    chk("multi_cnt", 32'(err_cnt), 32'(multi_cnt));

    // Lane0 to NEG, disable for one cycle, then re-enable
    step(N4, NEU, NEU, NEU, 1'b1, 4'hF, 1'b0);
    chk("l0_neg", 32'(rd_state[1:0]), 32'h2);
    step(N4, NEU, NEU, NEU, 1'b1, 4'hE, 1'b0);
    chk("dis_state", 32'(rd_state[1:0]), 32'h0);
    chk("dis_err",   32'(rd_err),        32'h0);
    chk("dis_cnt",   32'(err_cnt[1:0]),  32'h1);
    step(N4, NEU, NEU, NEU, 1'b1, 4'hF, 1'b0);
    chk("reen_state", 32'(rd_state[1:0]), 32'h2);
    chk("reen_err",   32'(rd_err),        32'h0);

    // Mid-stream reset discards an erroring symbol
    rst = 1'b0;
    step(N4, P6, P6, P6, 1'b1, 4'hF, 1'b0);
    chk("mid_rst_state",  32'(rd_state),   32'h0);
    chk("mid_rst_err",    32'(rd_err),     32'h0);
    chk("mid_rst_cnt",    32'(err_cnt),    32'h0);
    chk("mid_rst_sticky", 32'(err_sticky), 32'h0);
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
